// File: rtl/shift_pkg.sv
// Shared constants and state type for the multi-position shift sequencer.
// Shifter select codes match the external single-step shifter datapath.
package shift_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] SEL_PASS = 4'b0000;
    localparam logic [3:0] SEL_SHL  = 4'b0010;
    localparam logic [3:0] SEL_SHR  = 4'b0100;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/shift_sequencer.sv
// Drives the shared single-step shifter once per cycle until the requested count is used up.
// Optional rotate mode (input rot) is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] amount,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] sh_B,
    output logic [3:0]       sh_S,
    input  logic [WIDTH-1:0] sh_H,
    input  logic             sh_Il,
    input  logic             sh_Ir,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             rot,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   work_step;
    logic [CNT_W-1:0]   cnt_q;
    logic               dir_q;
    logic               last_step;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic               rot_q;
`endif

    assign sh_B      = work_q;
    assign busy      = (state_q != IDLE);
    assign last_step = (cnt_q == CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        sh_S    = SEL_PASS;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                sh_S = dir_q ? SEL_SHR : SEL_SHL;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next work value: shifter output, optionally with the ejected bit wrapped into the vacated slot.
    always_comb begin
        work_step = sh_H;
`ifdef SHIFT_SEQ_ROTATE_EN
        if (rot_q) begin
            if (dir_q) begin
                work_step[WIDTH-1] = sh_Ir;
            end else begin
                work_step[0] = sh_Il;
            end
        end
`endif
    end

    // result is loaded on entry to DONE so it is already valid while done is high.
    // NOTE: every datapath register is cleared by reset; an abort leaves no partial result visible.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work_q    <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        work_q    <= operand;
                        cnt_q     <= amount;
                        dir_q     <= dir;
                        carry_out <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
                        rot_q     <= rot;
`endif
                        if (amount == '0) begin
                            result <= operand;
                        end
                    end
                end
                SHIFT: begin
                    work_q    <= work_step;
                    carry_out <= dir_q ? sh_Ir : sh_Il;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (last_step) begin
                        result <= work_step;
                    end
                end
                DONE: begin
                    result <= work_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural shifter and result model.
// Define SHIFT_SEQ_ROTATE_EN for both bench and RTL to exercise rotate mode.
module tb_shift_sequencer;

    localparam int W = 16;
    localparam logic [3:0] PASS = 4'b0000;
    localparam logic [3:0] SHL  = 4'b0010;
    localparam logic [3:0] SHR  = 4'b0100;
`ifdef SHIFT_SEQ_ROTATE_EN
    localparam bit ROT_BUILT = 1'b1;
`else
    localparam bit ROT_BUILT = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic         dir;
    logic [3:0]   amount;
    logic [W-1:0] operand;
    logic [W-1:0] sh_B;
    logic [3:0]   sh_S;
    logic [W-1:0] sh_H;
    logic         sh_Il;
    logic         sh_Ir;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic         rot;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .dir       (dir),
        .amount    (amount),
        .operand   (operand),
        .sh_B      (sh_B),
        .sh_S      (sh_S),
        .sh_H      (sh_H),
        .sh_Il     (sh_Il),
        .sh_Ir     (sh_Ir),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rot       (rot),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clock = ~clock;

    // External single-step shifter: zero-fill, ejected bits on sh_Il / sh_Ir.
    always_comb begin
        sh_Il = sh_B[W-1];
        sh_Ir = sh_B[0];
        case (sh_S)
            SHL:     sh_H = sh_B << 1;
            SHR:     sh_H = sh_B >> 1;
            default: sh_H = sh_B;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-operation model: {carry, result} straight from shift/rotate arithmetic.
    function automatic logic [W:0] ref_model(input logic [W-1:0] op, input logic d,
                                             input logic r, input logic [3:0] amt);
        int a;
        logic [W-1:0] res;
        logic c;
        a = int'(amt);
        if (a == 0) return {1'b0, op};
        if (!d) begin
            res = op << a;
            if (r) res = res | (op >> (W - a));
            c = op[W - a];
        end else begin
            res = op >> a;
            if (r) res = res | (op << (W - a));
            c = op[a - 1];
        end
        return {c, res};
    endfunction

    // One request; spur_cyc > 0 injects an extra start while busy in that cycle.
    task automatic run_op(input logic [W-1:0] op, input logic d, input logic r,
                          input logic [3:0] amt, input int spur_cyc);
        logic [W:0] exp;
        logic [3:0] exp_sel;
        bit seen;
        exp     = ref_model(op, d, r & ROT_BUILT, amt);
        exp_sel = d ? SHR : SHL;
        seen    = 1'b0;
        @(negedge clock);
        operand = op;
        dir     = d;
        amount  = amt;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot     = r;
`endif
        start   = 1'b1;
        @(negedge clock);
        operand = W'($urandom);
        amount  = 4'($urandom);
        dir     = ~d;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (c > 1) @(negedge clock);
            start = (c == spur_cyc);
            if (done) begin
                seen = 1'b1;
                check("done_latency", c, int'(amt) + 1);
                check("result", result, exp[W-1:0]);
                check("carry_out", carry_out, exp[W]);
                check("busy_at_done", busy, 1'b1);
                check("sel_at_done", sh_S, PASS);
                start = 1'b1;
            end else begin
                check("busy_shift", busy, 1'b1);
                check("sel_shift", sh_S, (c <= int'(amt)) ? exp_sel : PASS);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge clock);
        start = 1'b0;
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("hold_result", result, exp[W-1:0]);
        check("hold_carry", carry_out, exp[W]);
        @(negedge clock);
        check("no_extra_done", done, 1'b0);
        check("start_in_done_ignored", busy, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        dir     = 1'b0;
        amount  = '0;
        operand = '0;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot     = 1'b0;
`endif
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 16'h0000);
        check("rst_carry", carry_out, 1'b0);
        check("rst_sel", sh_S, PASS);
        check("rst_shB", sh_B, 16'h0000);
        @(negedge clock);
        reset_n = 1'b1;

        run_op(16'h8001, 1'b0, 1'b0, 4'd1,  0);
        run_op(16'h00F3, 1'b1, 1'b0, 4'd4,  0);
        run_op(16'hABCD, 1'b0, 1'b0, 4'd0,  0);
        run_op(16'hFFFF, 1'b0, 1'b0, 4'd15, 5);

        // Abort mid-operation: outputs clear at once and no done follows.
        @(negedge clock);
        operand = 16'h1234;
        dir     = 1'b0;
        amount  = 4'd10;
        start   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("pre_abort_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 16'h0000);
        check("abort_carry", carry_out, 1'b0);
        check("abort_sel", sh_S, PASS);
        repeat (3) begin
            @(negedge clock);
            check("abort_no_done", done, 1'b0);
        end
        reset_n = 1'b1;
        run_op(16'h1234, 1'b1, 1'b0, 4'd3, 0);

        run_op(16'h8001, 1'b0, 1'b1, 4'd1, 0);
        run_op(16'h000F, 1'b1, 1'b1, 4'd4, 0);

        for (int i = 0; i < 24; i++) begin
            logic [3:0] amt;
            amt = 4'($urandom);
            run_op(W'($urandom), 1'($urandom), 1'($urandom), amt,
                   (amt > 1) ? int'($urandom_range(1, int'(amt))) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
